// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between the redirect sources / IF stage and pc_gen.
// master is the pc_gen side (it owns the PC valid/ready producer role); slave is the surrounding pipeline.
interface pc_gen_if #(
    parameter int XLEN        = 32,
    parameter int FETCH_WIDTH = 1,
    parameter int CAUSE_W     = 5
);
    logic                   trap_flag_i;
    logic                   trap_intr_i;
    logic [CAUSE_W-1:0]     trap_cause_i;
    logic [XLEN-1:0]        mtvec_i;
    logic                   mret_flag_i;
    logic [XLEN-1:0]        mepc_i;
    logic                   jump_flag_i;
    logic [XLEN-1:0]        jump_addr_i;
    logic                   hold_flag_i;
    logic                   fetch_ready_i;
    logic [XLEN-1:0]        pc_o;
    logic                   pc_valid_o;
    logic [FETCH_WIDTH-1:0] slot_valid_o;
    logic                   redirect_o;
    logic                   misalign_o;

    modport master (
        input  trap_flag_i, trap_intr_i, trap_cause_i, mtvec_i,
        input  mret_flag_i, mepc_i, jump_flag_i, jump_addr_i,
        input  hold_flag_i, fetch_ready_i,
        output pc_o, pc_valid_o, slot_valid_o, redirect_o, misalign_o
    );

    modport slave (
        output trap_flag_i, trap_intr_i, trap_cause_i, mtvec_i,
        output mret_flag_i, mepc_i, jump_flag_i, jump_addr_i,
        output hold_flag_i, fetch_ready_i,
        input  pc_o, pc_valid_o, slot_valid_o, redirect_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-group PC generator with trap/mret/jump redirect and per-slot valid mask.
// Latency: all outputs registered, one cycle after the deciding edge; no comb input-to-output path.
// Backpressure: !fetch_ready_i or hold_flag_i freezes sequential advance; redirects always win.
module pc_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_ADDR  = '0,
    parameter int              FETCH_WIDTH = 1,
    parameter int              CAUSE_W     = 5
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);
    localparam int              GB       = 4 * FETCH_WIDTH;
    localparam logic [XLEN-1:0] GB_MASK  = XLEN'(GB - 1);
    localparam logic [XLEN-1:0] GB_BYTES = XLEN'(GB);

    logic [XLEN-1:0]        pc_q;
    logic                   pc_valid_q;
    logic                   redirect_q;
    logic                   misalign_q;
    logic [FETCH_WIDTH-1:0] slot_q;

    logic [XLEN-1:0]        trap_base;
    logic [XLEN-1:0]        trap_target;
    logic [XLEN-1:0]        next_pc;
    logic [XLEN-1:0]        next_off;
    logic                   redirect_n;
    logic                   misalign_n;
    logic [FETCH_WIDTH-1:0] slot_n;

    // Only vectored mode with an interrupt offsets by cause; modes 2/3 fall back to direct.
    always_comb begin
        trap_base = {bus.mtvec_i[XLEN-1:2], 2'b00};
        if (bus.mtvec_i[1:0] == 2'b01 && bus.trap_intr_i)
            trap_target = trap_base + {{(XLEN-CAUSE_W-2){1'b0}}, bus.trap_cause_i, 2'b00};
        else
            trap_target = trap_base;
    end

    always_comb begin
        next_pc    = pc_q;
        redirect_n = 1'b0;
        misalign_n = 1'b0;
        if (bus.trap_flag_i) begin
            next_pc    = trap_target;
            redirect_n = 1'b1;
        end else if (bus.mret_flag_i) begin
            if (bus.mepc_i[1:0] != 2'b00) begin
                misalign_n = 1'b1;
            end else begin
                next_pc    = bus.mepc_i;
                redirect_n = 1'b1;
            end
        end else if (bus.jump_flag_i) begin
            if (bus.jump_addr_i[1:0] != 2'b00) begin
                misalign_n = 1'b1;
            end else begin
                next_pc    = bus.jump_addr_i;
                redirect_n = 1'b1;
            end
        end else if (pc_valid_q && bus.fetch_ready_i && !bus.hold_flag_i) begin
            // Advancing from the group base realigns a mid-group redirect target.
            next_pc = (pc_q & ~GB_MASK) + GB_BYTES;
        end
    end

    always_comb begin
        next_off = next_pc & GB_MASK;
        slot_n   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            slot_n[i] = (XLEN'(4 * i) >= next_off);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            slot_q     <= '0;
        end else begin
            pc_q       <= next_pc;
            pc_valid_q <= 1'b1;
            redirect_q <= redirect_n;
            misalign_q <= misalign_n;
            slot_q     <= slot_n;
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.pc_valid_o   = pc_valid_q;
    assign bus.slot_valid_o = slot_q;
    assign bus.redirect_o   = redirect_q;
    assign bus.misalign_o   = misalign_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with FETCH_WIDTH=1 and one with FETCH_WIDTH=4.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .FETCH_WIDTH(1), .CAUSE_W(5)) if1 ();
    pc_gen_if #(.XLEN(32), .FETCH_WIDTH(4), .CAUSE_W(5)) if4 ();

    pc_gen #(.XLEN(32), .RESET_ADDR(32'h0), .FETCH_WIDTH(1), .CAUSE_W(5)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    pc_gen #(.XLEN(32), .RESET_ADDR(32'h0), .FETCH_WIDTH(4), .CAUSE_W(5)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if1.trap_flag_i = 0; if1.trap_intr_i = 0; if1.trap_cause_i = '0; if1.mtvec_i = '0;
        if1.mret_flag_i = 0; if1.mepc_i = '0; if1.jump_flag_i = 0; if1.jump_addr_i = '0;
        if1.hold_flag_i = 0; if1.fetch_ready_i = 1;
        if4.trap_flag_i = 0; if4.trap_intr_i = 0; if4.trap_cause_i = '0; if4.mtvec_i = '0;
        if4.mret_flag_i = 0; if4.mepc_i = '0; if4.jump_flag_i = 0; if4.jump_addr_i = '0;
        if4.hold_flag_i = 0; if4.fetch_ready_i = 1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'd0, 32'd4, 32'd8, 32'd12};
        rst = 1;
        repeat (3) step();
        n_checks++;
        if (if1.pc_o !== 32'h0 || if1.pc_valid_o !== 1'b0 || if1.slot_valid_o !== 1'b0 ||
            if1.redirect_o !== 1'b0 || if1.misalign_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_w1: pc=%h vld=%b slot=%b red=%b mis=%b, want 0/0/0/0/0",
                     if1.pc_o, if1.pc_valid_o, if1.slot_valid_o, if1.redirect_o, if1.misalign_o);
        end
        n_checks++;
        if (if4.pc_o !== 32'h0 || if4.pc_valid_o !== 1'b0 || if4.slot_valid_o !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_w4: pc=%h vld=%b slot=%b, want 0/0/0000",
                     if4.pc_o, if4.pc_valid_o, if4.slot_valid_o);
        end
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (if1.pc_o !== exp_seq[k] || if1.pc_valid_o !== 1'b1 || if1.slot_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL seq_%0d: pc=%h vld=%b slot=%b, want %h/1/1",
                         k, if1.pc_o, if1.pc_valid_o, if1.slot_valid_o, exp_seq[k]);
            end
        end
        // dut4 after the release edge and three advances: 0 -> 16 -> 32 -> 48
        n_checks++;
        if (if4.pc_o !== 32'd48 || if4.slot_valid_o !== 4'b1111) begin
            n_errors++;
            $display("FAIL seq_w4: pc=%h slot=%b, want 00000030/1111", if4.pc_o, if4.slot_valid_o);
        end
    endtask

    task automatic test_hold();
        if1.hold_flag_i = 1;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin
                if1.hold_flag_i   = 0;
                if1.fetch_ready_i = 0;
            end
            step();
            n_checks++;
            if (if1.pc_o !== 32'd12 || if1.pc_valid_o !== 1'b1 || if1.slot_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL hold_%0d: pc=%h vld=%b slot=%b, want 0000000c/1/1",
                         k, if1.pc_o, if1.pc_valid_o, if1.slot_valid_o);
            end
        end
        if1.fetch_ready_i = 1;
        step();
        n_checks++;
        if (if1.pc_o !== 32'd16) begin
            n_errors++;
            $display("FAIL hold_resume: pc=%h, want 00000010", if1.pc_o);
        end
    endtask

    task automatic test_jump_over_hold();
        if4.jump_flag_i = 1;
        if4.jump_addr_i = 32'h0000_1008;
        if4.hold_flag_i = 1;
        step();
        n_checks++;
        if (if4.pc_o !== 32'h1008 || if4.slot_valid_o !== 4'b1100 || if4.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL jump_hold: pc=%h slot=%b red=%b, want 00001008/1100/1",
                     if4.pc_o, if4.slot_valid_o, if4.redirect_o);
        end
        if4.jump_flag_i = 0;
        step();
        n_checks++;
        if (if4.pc_o !== 32'h1008 || if4.redirect_o !== 1'b0) begin
            n_errors++;
            $display("FAIL jump_pulse: pc=%h red=%b, want 00001008/0", if4.pc_o, if4.redirect_o);
        end
        if4.hold_flag_i = 0;
        step();
        n_checks++;
        if (if4.pc_o !== 32'h1010 || if4.slot_valid_o !== 4'b1111) begin
            n_errors++;
            $display("FAIL jump_realign: pc=%h slot=%b, want 00001010/1111",
                     if4.pc_o, if4.slot_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        if4.jump_flag_i = 1;
        if4.jump_addr_i = 32'h0000_2004;
        step();
        n_checks++;
        if (if4.pc_o !== 32'h2004 || if4.slot_valid_o !== 4'b1110 || if4.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_1: pc=%h slot=%b red=%b, want 00002004/1110/1",
                     if4.pc_o, if4.slot_valid_o, if4.redirect_o);
        end
        if4.jump_addr_i = 32'h0000_300C;
        step();
        n_checks++;
        if (if4.pc_o !== 32'h300C || if4.slot_valid_o !== 4'b1000 || if4.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_2: pc=%h slot=%b red=%b, want 0000300c/1000/1",
                     if4.pc_o, if4.slot_valid_o, if4.redirect_o);
        end
        if4.jump_flag_i = 0;
        step();
        n_checks++;
        if (if4.pc_o !== 32'h3010 || if4.slot_valid_o !== 4'b1111 || if4.redirect_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_3: pc=%h slot=%b red=%b, want 00003010/1111/0",
                     if4.pc_o, if4.slot_valid_o, if4.redirect_o);
        end
    endtask

    task automatic test_trap();
        if1.trap_flag_i  = 1;
        if1.trap_intr_i  = 1;
        if1.trap_cause_i = 5'd7;
        if1.mtvec_i      = 32'h0000_0801;
        if1.jump_flag_i  = 1;
        if1.jump_addr_i  = 32'h0000_0040;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h081C || if1.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL trap_vec: pc=%h red=%b, want 0000081c/1", if1.pc_o, if1.redirect_o);
        end
        if1.trap_intr_i = 0;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0800) begin
            n_errors++;
            $display("FAIL trap_exc: pc=%h, want 00000800", if1.pc_o);
        end
        if1.trap_intr_i = 1;
        if1.mtvec_i     = 32'h0000_0903;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0900) begin
            n_errors++;
            $display("FAIL trap_mode3: pc=%h, want 00000900", if1.pc_o);
        end
        if1.trap_flag_i = 0;
        if1.mret_flag_i = 1;
        if1.mepc_i      = 32'h0000_0200;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0200 || if1.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL mret: pc=%h red=%b, want 00000200/1", if1.pc_o, if1.redirect_o);
        end
        // trap outranks an mret whose target would be misaligned
        if1.trap_flag_i = 1;
        if1.trap_intr_i = 0;
        if1.mtvec_i     = 32'h0000_0401;
        if1.mepc_i      = 32'h0000_0202;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0400 || if1.misalign_o !== 1'b0 || if1.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL trap_over_mret: pc=%h mis=%b red=%b, want 00000400/0/1",
                     if1.pc_o, if1.misalign_o, if1.redirect_o);
        end
        idle_inputs();
    endtask

    task automatic test_misalign();
        if1.jump_flag_i = 1;
        if1.jump_addr_i = 32'h0000_0102;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0400 || if1.misalign_o !== 1'b1 || if1.redirect_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mis_jump: pc=%h mis=%b red=%b, want 00000400/1/0",
                     if1.pc_o, if1.misalign_o, if1.redirect_o);
        end
        if1.jump_flag_i = 0;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0404 || if1.misalign_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mis_jump_clear: pc=%h mis=%b, want 00000404/0", if1.pc_o, if1.misalign_o);
        end
        if1.mret_flag_i = 1;
        if1.mepc_i      = 32'h0000_0201;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0404 || if1.misalign_o !== 1'b1 || if1.redirect_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mis_mret: pc=%h mis=%b red=%b, want 00000404/1/0",
                     if1.pc_o, if1.misalign_o, if1.redirect_o);
        end
        if1.mret_flag_i = 0;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0408 || if1.misalign_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mis_mret_clear: pc=%h mis=%b, want 00000408/0", if1.pc_o, if1.misalign_o);
        end
    endtask

    task automatic test_wrap_and_reset();
        if1.jump_flag_i = 1;
        if1.jump_addr_i = 32'hFFFF_FFFC;
        step();
        n_checks++;
        if (if1.pc_o !== 32'hFFFF_FFFC || if1.redirect_o !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_load: pc=%h red=%b, want fffffffc/1", if1.pc_o, if1.redirect_o);
        end
        if1.jump_flag_i = 0;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0 || if1.redirect_o !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap: pc=%h red=%b, want 00000000/0", if1.pc_o, if1.redirect_o);
        end
        step();
        if1.trap_flag_i = 1;
        if1.mtvec_i     = 32'h0000_0801;
        if1.trap_intr_i = 1;
        if1.trap_cause_i = 5'd3;
        rst = 1;
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0 || if1.pc_valid_o !== 1'b0 || if1.redirect_o !== 1'b0 ||
            if1.slot_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_trap: pc=%h vld=%b red=%b slot=%b, want 0/0/0/0",
                     if1.pc_o, if1.pc_valid_o, if1.redirect_o, if1.slot_valid_o);
        end
        rst = 0;
        idle_inputs();
        step();
        n_checks++;
        if (if1.pc_o !== 32'h0 || if1.pc_valid_o !== 1'b1 || if1.slot_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_release: pc=%h vld=%b slot=%b, want 0/1/1",
                     if1.pc_o, if1.pc_valid_o, if1.slot_valid_o);
        end
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_hold();
        test_jump_over_hold();
        test_back_to_back();
        test_trap();
        test_misalign();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
